// File: rtl/dzwiek_sekwencer.sv
// dzwiek_sekwencer: plays a fixed 16-entry melody ROM as a square wave on oSOUND
// Ports: iCLK clock, iRST sync active-high reset, iSTART start (IDLE only),
// iSTOP abort (any state), oSOUND tone output, oBUSY melody in progress,
// oDONE end-of-melody pulse, oNOTE pitch index currently sounding.
module dzwiek_sekwencer #(
    parameter int TICK_DIV = 500000,
    parameter int HP_SHIFT = 0,
    parameter int LOOP     = 0
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic       iSTOP,
    output logic       oSOUND,
    output logic       oBUSY,
    output logic       oDONE,
    output logic [2:0] oNOTE
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [2:0]    pitch_q, pitch_d;
    logic [4:0]    dur_q, dur_d;
    logic [4:0]    tick_q, tick_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [16:0]   phase_q, phase_d;
    logic          sound_q, sound_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    note_q, note_d;
    logic [7:0]    rom;
    logic [16:0]   hp_raw, hp;
    logic          tick_end, at_end, wrap;

    always_comb begin
        rom = 8'd0;
        case (addr_q[3:0])
            4'd0: rom = {3'd1, 5'd20};
            4'd1: rom = {3'd3, 5'd20};
            4'd2: rom = {3'd5, 5'd20};
            4'd3: rom = {3'd0, 5'd10};
            4'd4: rom = {3'd5, 5'd10};
            4'd5: rom = {3'd6, 5'd10};
            4'd6: rom = {3'd7, 5'd30};
            default: rom = 8'd0;
        endcase
    end

    always_comb begin
        hp_raw = 17'd1;
        case (pitch_q)
            3'd1: hp_raw = 17'd95554;
            3'd2: hp_raw = 17'd85131;
            3'd3: hp_raw = 17'd75843;
            3'd4: hp_raw = 17'd71586;
            3'd5: hp_raw = 17'd63776;
            3'd6: hp_raw = 17'd56818;
            3'd7: hp_raw = 17'd50619;
            default: hp_raw = 17'd1;
        endcase
    end

    assign hp       = hp_raw >> HP_SHIFT;
    assign tick_end = presc_q == PRE_LAST;
    // addr bit 4 marks running off the end of entry 15
    assign at_end   = rom[4:0] == 5'd0 || addr_q[4];
    assign wrap     = phase_q == hp - 17'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pitch_d = pitch_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        presc_d = presc_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_d = LOAD;
                    addr_d  = 5'd0;
                end
            end
            LOAD: begin
                pitch_d = rom[7:5];
                dur_d   = rom[4:0];
                tick_d  = 5'd0;
                presc_d = '0;
                phase_d = 17'd0;
                if (!at_end) state_d = PLAY;
                else if (LOOP != 0) addr_d = 5'd0;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            PLAY: begin
                presc_d = tick_end ? '0 : presc_q + PW'(1);
                phase_d = wrap ? 17'd0 : phase_q + 17'd1;
                if (tick_end) begin
                    tick_d = tick_q + 5'd1;
                    if (tick_q == dur_q - 5'd1) begin
                        state_d = GAP;
                        tick_d  = 5'd0;
                    end
                end
            end
            GAP: begin
                presc_d = tick_end ? '0 : presc_q + PW'(1);
                if (tick_end) begin
                    state_d = LOAD;
                    addr_d  = addr_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (iSTOP) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
        // outputs are registered from the next state so they line up with it
        busy_d  = state_d != IDLE;
        note_d  = state_d == PLAY ? pitch_d : 3'd0;
        sound_d = state_d != PLAY ? 1'b0 :
                  (state_q == PLAY && pitch_q != 3'd0 && wrap) ? ~sound_q : sound_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            addr_q  <= 5'd0;
            pitch_q <= 3'd0;
            dur_q   <= 5'd0;
            tick_q  <= 5'd0;
            presc_q <= '0;
            phase_q <= 17'd0;
            sound_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            note_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pitch_q <= pitch_d;
            dur_q   <= dur_d;
            tick_q  <= tick_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            sound_q <= sound_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            note_q  <= note_d;
        end
    end

    assign oSOUND = sound_q;
    assign oBUSY  = busy_q;
    assign oDONE  = done_q;
    assign oNOTE  = note_q;
endmodule

// File: tb/tb_dzwiek_sekwencer.sv
// tb_dzwiek_sekwencer: scoreboard bench for the melody sequencer
module tb_dzwiek_sekwencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, start_l = 1'b0, stop_l = 1'b0;
    logic       snd, busy, done, snd_l, busy_l, done_l;
    logic [2:0] note, note_l;
    int         cyc = 0, pass_cnt = 0, total = 0;

    typedef struct {int c; logic [2:0] n;} ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dzwiek_sekwencer #(.TICK_DIV(100), .HP_SHIFT(10), .LOOP(0)) u_dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iSTOP(stop),
        .oSOUND(snd), .oBUSY(busy), .oDONE(done), .oNOTE(note));

    dzwiek_sekwencer #(.TICK_DIV(100), .HP_SHIFT(10), .LOOP(1)) u_loop (
        .iCLK(clk), .iRST(rst), .iSTART(start_l), .iSTOP(stop_l),
        .oSOUND(snd_l), .oBUSY(busy_l), .oDONE(done_l), .oNOTE(note_l));

    task automatic kick(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_k(input int t0, input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic halt();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_melody(input int t0);
        int mp[7] = '{1, 3, 5, 0, 5, 6, 7};
        int md[7] = '{20, 20, 20, 10, 10, 10, 30};
        int l = t0 + 1;
        for (int i = 0; i < 7; i++) begin
            if (mp[i] != 0) begin
                exp_q.push_back('{l + 1, 3'(mp[i])});
                exp_q.push_back('{l + 1 + md[i] * 100, 3'd0});
            end
            l += 1 + md[i] * 100 + 100;
        end
    endtask

    task automatic test_reset();
        int act = 0;
        repeat (5) @(negedge clk);
        total++; if (snd !== 1'b0) $display("FAIL rst_sound: got %b want 0", snd); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        total++; if (note !== 3'd0) $display("FAIL rst_note: got %0d want 0", note); else pass_cnt++;
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (snd || busy || done || snd_l || busy_l) act++;
        end
        total++; if (act !== 0) $display("FAIL idle_quiet: got %0d active cycles want 0", act); else pass_cnt++;
    endtask

    task automatic test_first_note();
        int t0;
        int tg[3] = '{-1, -1, -1};
        int n = 0;
        logic prev = 1'b0;
        kick(t0);
        total++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else pass_cnt++;
        total++; if (note !== 3'd0) $display("FAIL load_note: got %0d want 0", note); else pass_cnt++;
        wait_k(t0, 2);
        total++; if (note !== 3'd1) $display("FAIL first_note: got %0d want 1", note); else pass_cnt++;
        while (cyc - t0 < 2002) begin
            if (snd !== prev && n < 3) begin
                tg[n] = cyc - t0;
                n++;
            end
            prev = snd;
            @(negedge clk);
        end
        total++; if (tg[0] !== 95) $display("FAIL toggle0: got %0d want 95", tg[0]); else pass_cnt++;
        total++; if (tg[1] !== 188) $display("FAIL toggle1: got %0d want 188", tg[1]); else pass_cnt++;
        total++; if (tg[2] !== 281) $display("FAIL toggle2: got %0d want 281", tg[2]); else pass_cnt++;
        total++; if (note !== 3'd0) $display("FAIL gap_note: got %0d want 0", note); else pass_cnt++;
        total++; if (snd !== 1'b0) $display("FAIL gap_sound: got %b want 0", snd); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", busy); else pass_cnt++;
        halt();
    endtask

    task automatic watch_melody(input bit poke, input string tag);
        int t0, done_c = -1, done_len = 0, busy_fall = -1, rest_hi = 0;
        logic [2:0] prev = 3'd0;
        ev_t e;
        kick(t0);
        push_melody(t0);
        while (cyc - t0 < 12715) begin
            if (poke) start = (cyc - t0 == 500);
            if (note !== prev) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL %s_extra_note: got %0d at %0d want none", tag, note, cyc - t0);
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.c || note !== e.n)
                        $display("FAIL %s_note: got %0d at %0d want %0d at %0d", tag, note, cyc - t0, e.n, e.c - t0);
                    else pass_cnt++;
                end
            end
            prev = note;
            if (cyc - t0 >= 6305 && cyc - t0 <= 7304 && snd) rest_hi++;
            if (done) begin
                done_len++;
                if (done_c < 0) done_c = cyc - t0;
            end
            if (!busy && busy_fall < 0) busy_fall = cyc - t0;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (exp_q.size() !== 0) $display("FAIL %s_missing: got %0d left want 0", tag, exp_q.size()); else pass_cnt++;
        exp_q.delete();
        total++; if (rest_hi !== 0) $display("FAIL %s_rest: got %0d high cycles want 0", tag, rest_hi); else pass_cnt++;
        total++; if (done_c !== 12709) $display("FAIL %s_done_at: got %0d want 12709", tag, done_c); else pass_cnt++;
        total++; if (done_len !== 1) $display("FAIL %s_done_len: got %0d want 1", tag, done_len); else pass_cnt++;
        total++; if (busy_fall !== 12709) $display("FAIL %s_busy_fall: got %0d want 12709", tag, busy_fall); else pass_cnt++;
    endtask

    task automatic test_stop();
        int t0, bad = 0;
        kick(t0);
        wait_k(t0, 3000);
        total++; if (note !== 3'd3) $display("FAIL stop_pre_note: got %0d want 3", note); else pass_cnt++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (note !== 3'd0) $display("FAIL stop_note: got %0d want 0", note); else pass_cnt++;
        total++; if (snd !== 1'b0) $display("FAIL stop_sound: got %b want 0", snd); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL stop_done: got %b want 0", done); else pass_cnt++;
        repeat (300) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        total++; if (bad !== 0) $display("FAIL stop_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL start_stop_same: got busy %b want 0", busy); else pass_cnt++;
        kick(t0);
        wait_k(t0, 2);
        total++; if (note !== 3'd1) $display("FAIL restart_note: got %0d want 1", note); else pass_cnt++;
        halt();
    endtask

    task automatic test_mid_reset();
        int t0;
        kick(t0);
        wait_k(t0, 1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || note !== 3'd0 || snd !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_out: got busy %b note %0d snd %b done %b want all 0", busy, note, snd, done);
        else pass_cnt++;
        kick(t0);
        wait_k(t0, 2);
        total++; if (note !== 3'd1) $display("FAIL midrst_replay: got %0d want 1", note); else pass_cnt++;
        halt();
    endtask

    task automatic test_loop();
        int t0, drops = 0, dones = 0;
        logic [2:0] n9 = 3'd7, n10 = 3'd7;
        @(negedge clk);
        start_l = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_l = 1'b0;
        while (cyc - t0 < 12720) begin
            if (!busy_l) drops++;
            if (done_l) dones++;
            if (cyc - t0 == 12709) n9 = note_l;
            if (cyc - t0 == 12710) n10 = note_l;
            @(negedge clk);
        end
        total++; if (n9 !== 3'd0) $display("FAIL loop_reload_note: got %0d want 0", n9); else pass_cnt++;
        total++; if (n10 !== 3'd1) $display("FAIL loop_replay: got %0d want 1", n10); else pass_cnt++;
        total++; if (drops !== 0) $display("FAIL loop_busy: got %0d idle cycles want 0", drops); else pass_cnt++;
        total++; if (dones !== 0) $display("FAIL loop_done: got %0d pulses want 0", dones); else pass_cnt++;
        stop_l = 1'b1;
        @(negedge clk);
        stop_l = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_note();
        watch_melody(1'b0, "melody");
        test_stop();
        watch_melody(1'b1, "busy_start");
        test_mid_reset();
        test_loop();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
